// File: rtl/icb_pkg.sv
// Shared ICB definitions: bus widths, command/response entry layouts and a
// small helper for FIFO pointer sizing. Used by the bridge, its interface
// and the FIFO sub-module.
package icb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  // One queued command is {read, addr, wdata, wmask} = 69 bits
  localparam int CMD_W = 1 + ADDR_W + DATA_W + MASK_W;

  // One queued response is {rdata, err}
  localparam int RSP_W = DATA_W + 1;

  // Outstanding-transaction counter width (limit is at most 15)
  localparam int OUTS_W = 4;

  typedef struct packed {
    logic              read;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } icb_cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } icb_rsp_t;

  // Pointers carry one extra wrap bit so full and empty can be told apart
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/icb_pipe_bridge_if.sv
// ICB bus bundle: command channel (master to slave) and response channel
// (slave to master). The bridge is a slave upstream and a master downstream.
interface icb_pipe_bridge_if;
  import icb_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_read;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [MASK_W-1:0] cmd_wmask;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/icb_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. Pushes into a full FIFO and pops
// from an empty one are ignored, so callers may present raw requests.
// Output data is the head entry, read straight from storage (no bypass).
module icb_sync_fifo
  import icb_pkg::*;
#(
  parameter int WIDTH = CMD_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the writer lapped the reader
  assign full    = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer advance; cleared asynchronously so reset drops all entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  // Entry storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/icb_pipe_bridge.sv
// ICB pipeline bridge: registers upstream commands through a FIFO toward the
// downstream slave and limits the number of outstanding transactions.
// Optional feature: define ICB_PIPE_BRIDGE_RSP_BUF_EN to add a response FIFO
// (one cycle of response latency); otherwise responses pass straight through.
module icb_pipe_bridge
  import icb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int OUTS_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  icb_pipe_bridge_if.slave         i_icb,
  icb_pipe_bridge_if.master        o_icb,
  output logic                     busy
);

  localparam logic [OUTS_W-1:0] OUTS_LIM = OUTS_W'(OUTS_MAX);

  icb_cmd_t          cmd_in;
  icb_cmd_t          cmd_out;
  logic              cmd_full;
  logic              cmd_empty;
  logic              cmd_ready;
  logic              cmd_push;
  logic              cmd_pop;
  logic              rsp_valid_up;
  logic              rsp_hs;
  logic [OUTS_W-1:0] outs_cnt;

  // ---------------------------------------------------------------------
  // Command path
  // ---------------------------------------------------------------------
  assign cmd_in = '{read:  i_icb.cmd_read,
                    addr:  i_icb.cmd_addr,
                    wdata: i_icb.cmd_wdata,
                    wmask: i_icb.cmd_wmask};

  // Ready ignores a same-cycle pop so a full FIFO never takes a push
  assign cmd_ready       = !cmd_full && (outs_cnt < OUTS_LIM) && !rst;
  assign i_icb.cmd_ready = cmd_ready;
  assign cmd_push        = i_icb.cmd_valid && cmd_ready;
  assign cmd_pop         = !cmd_empty && o_icb.cmd_ready;

  icb_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .wdata (cmd_in),
    .pop   (cmd_pop),
    .rdata (cmd_out),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  assign o_icb.cmd_valid = !cmd_empty;
  assign o_icb.cmd_read  = cmd_out.read;
  assign o_icb.cmd_addr  = cmd_out.addr;
  assign o_icb.cmd_wdata = cmd_out.wdata;
  assign o_icb.cmd_wmask = cmd_out.wmask;

  // ---------------------------------------------------------------------
  // Response path
  // A legitimate downstream response always belongs to an outstanding
  // transaction, so responses arriving while not busy are stale (issued
  // before a reset) and are swallowed instead of being forwarded.
  // ---------------------------------------------------------------------
`ifdef ICB_PIPE_BRIDGE_RSP_BUF_EN
  icb_rsp_t rsp_in;
  icb_rsp_t rsp_out;
  logic     rsp_full;
  logic     rsp_empty;

  assign rsp_in = '{rdata: o_icb.rsp_rdata, err: o_icb.rsp_err};

  icb_sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (o_icb.rsp_valid && busy),
    .wdata (rsp_in),
    .pop   (i_icb.rsp_ready),
    .rdata (rsp_out),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  assign o_icb.rsp_ready = !rsp_full;
  assign rsp_valid_up    = !rsp_empty;
  assign i_icb.rsp_rdata = rsp_out.rdata;
  assign i_icb.rsp_err   = rsp_out.err;
`else
  // busy is cleared asynchronously, so this is also low throughout reset
  assign rsp_valid_up    = o_icb.rsp_valid && busy;
  assign o_icb.rsp_ready = i_icb.rsp_ready;
  assign i_icb.rsp_rdata = o_icb.rsp_rdata;
  assign i_icb.rsp_err   = o_icb.rsp_err;
`endif

  assign i_icb.rsp_valid = rsp_valid_up;
  assign rsp_hs          = rsp_valid_up && i_icb.rsp_ready;

  // ---------------------------------------------------------------------
  // Outstanding-transaction counter
  // ---------------------------------------------------------------------

  // Count accepted commands minus delivered responses; a simultaneous
  // accept and delivery leaves the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outs_cnt <= '0;
    end else if (cmd_push && !rsp_hs) begin
      outs_cnt <= outs_cnt + OUTS_W'(1);
    end else if (rsp_hs && !cmd_push && (outs_cnt != '0)) begin
      outs_cnt <= outs_cnt - OUTS_W'(1);
    end
  end

  assign busy = (outs_cnt != '0);

endmodule

// File: tb/tb_icb_pipe_bridge.sv
// Self-checking bench for icb_pipe_bridge (DEPTH=2, OUTS_MAX=4): a table of
// fill/backpressure vectors, directed sequences for latency, pass-through of
// response fields, outstanding limit and reset, then a randomized run scored
// against a queue-based model. Works with or without ICB_PIPE_BRIDGE_RSP_BUF_EN.
module tb_icb_pipe_bridge;
  import icb_pkg::*;

  localparam int DEPTH    = 2;
  localparam int OUTS_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int tests = 0;
  int fails = 0;

  icb_pipe_bridge_if up_if ();
  icb_pipe_bridge_if dn_if ();

  icb_pipe_bridge #(
    .DEPTH    (DEPTH),
    .OUTS_MAX (OUTS_MAX)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .i_icb (up_if),
    .o_icb (dn_if),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Table record: per-cycle inputs and expected command-side outputs
  typedef struct {
    logic        cv;
    logic        o_rdy;
    logic [31:0] addr;
    logic        exp_ready;
    logic        exp_ovalid;
    logic        exp_busy;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t     vecs [8];
  icb_cmd_t idle_cmd = '0;

  // Reference model state: commands waiting in the bridge, expected upstream
  // responses in order, responses the downstream slave still owes
  icb_cmd_t mq     [$];
  icb_rsp_t exp_q  [$];
  icb_rsp_t pend_q [$];
  int       outs;

  function automatic icb_cmd_t mk_cmd(input logic read, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] wmask);
    icb_cmd_t c;
    c.read  = read;
    c.addr  = addr;
    c.wdata = wdata;
    c.wmask = wmask;
    return c;
  endfunction

  // Behaviour of the downstream slave: response derived from the command
  function automatic icb_rsp_t slave_rsp(input icb_cmd_t c);
    icb_rsp_t r;
    r.rdata = c.addr + c.wdata;
    r.err   = c.read ^ c.wmask[0];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
    end
  endtask

  task automatic checkValue(input string name, input logic [95:0] actual, input logic [95:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveIdle();
    up_if.cmd_valid = 1'b0;
    up_if.cmd_read  = 1'b0;
    up_if.cmd_addr  = '0;
    up_if.cmd_wdata = '0;
    up_if.cmd_wmask = '0;
    up_if.rsp_ready = 1'b0;
    dn_if.cmd_ready = 1'b0;
    dn_if.rsp_valid = 1'b0;
    dn_if.rsp_rdata = '0;
    dn_if.rsp_err   = 1'b0;
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before sampling
  task automatic applyStimulus(input logic cv, input icb_cmd_t cmd, input logic o_rdy,
                               input logic orv, input logic [31:0] ordata,
                               input logic oerr, input logic irr);
    @(negedge clk);
    up_if.cmd_valid = cv;
    up_if.cmd_read  = cmd.read;
    up_if.cmd_addr  = cmd.addr;
    up_if.cmd_wdata = cmd.wdata;
    up_if.cmd_wmask = cmd.wmask;
    up_if.rsp_ready = irr;
    dn_if.cmd_ready = o_rdy;
    dn_if.rsp_valid = orv;
    dn_if.rsp_rdata = ordata;
    dn_if.rsp_err   = oerr;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    driveIdle();
    #1;
    checkOutput("rst_cmd_ready", up_if.cmd_ready, 1'b0);
    checkOutput("rst_cmd_valid", dn_if.cmd_valid, 1'b0);
    checkOutput("rst_rsp_valid", up_if.rsp_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One randomized cycle checked against the model; with allow_cmd low the
  // bench only drains (no new commands, both sides ready)
  task automatic randomCycle(input bit allow_cmd);
    icb_cmd_t c;
    icb_cmd_t dn_cmd;
    icb_rsp_t pr;
    icb_rsp_t got;
    logic     cv, ordy, orv, irr, exp_ready, q_nonempty;
    c    = mk_cmd(1'($urandom % 2), $urandom, $urandom, 4'($urandom));
    cv   = allow_cmd && (($urandom % 4) != 0);
    ordy = !allow_cmd || (($urandom % 3) != 0);
    irr  = !allow_cmd || (($urandom % 3) != 0);
    orv  = (pend_q.size() > 0) && (!allow_cmd || (($urandom % 3) != 0));
    pr   = (pend_q.size() > 0) ? pend_q[0] : '0;
    applyStimulus(cv, c, ordy, orv, pr.rdata, pr.err, irr);

    exp_ready  = (mq.size() < DEPTH) && (outs < OUTS_MAX);
    q_nonempty = (mq.size() > 0);
    dn_cmd = mk_cmd(dn_if.cmd_read, dn_if.cmd_addr, dn_if.cmd_wdata, dn_if.cmd_wmask);
    got.rdata = up_if.rsp_rdata;
    got.err   = up_if.rsp_err;

    checkOutput("rnd_cmd_ready", up_if.cmd_ready, exp_ready);
    checkOutput("rnd_cmd_valid", dn_if.cmd_valid, q_nonempty);
    checkOutput("rnd_busy", busy, outs != 0);
    if (q_nonempty) checkValue("rnd_cmd_data", 96'(dn_cmd), 96'(mq[0]));
    if (up_if.rsp_valid) begin
      if (exp_q.size() == 0) checkOutput("rnd_rsp_unexpected", up_if.rsp_valid, 1'b0);
      else                   checkValue("rnd_rsp_data", 96'(got), 96'(exp_q[0]));
    end

    if (orv && dn_if.rsp_ready) void'(pend_q.pop_front());
    if (q_nonempty && ordy) begin
      pend_q.push_back(slave_rsp(dn_cmd));
      void'(mq.pop_front());
    end
    if (cv && exp_ready) begin
      mq.push_back(c);
      exp_q.push_back(slave_rsp(c));
      outs++;
    end
    if (up_if.rsp_valid && irr && (exp_q.size() > 0)) begin
      void'(exp_q.pop_front());
      outs--;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   acc;
    int   rhs;
    int   guard;
    logic orv_b;

    // Fill/backpressure table: no responses, upstream response ready
    vecs[0] = '{1'b1, 1'b0, 32'hA000_0000, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'hA000_0001, 1'b1, 1'b1, 1'b1, 32'hA000_0000};
    vecs[2] = '{1'b1, 1'b0, 32'hA000_0002, 1'b0, 1'b1, 1'b1, 32'hA000_0000};
    vecs[3] = '{1'b1, 1'b1, 32'hA000_0003, 1'b0, 1'b1, 1'b1, 32'hA000_0000};
    vecs[4] = '{1'b1, 1'b0, 32'hA000_0004, 1'b1, 1'b1, 1'b1, 32'hA000_0001};
    vecs[5] = '{1'b0, 1'b1, 32'hA000_0005, 1'b0, 1'b1, 1'b1, 32'hA000_0001};
    vecs[6] = '{1'b0, 1'b1, 32'hA000_0006, 1'b1, 1'b1, 1'b1, 32'hA000_0004};
    vecs[7] = '{1'b0, 1'b1, 32'hA000_0007, 1'b1, 1'b0, 1'b1, 32'h0};

    rst = 1'b1;
    driveIdle();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("por_cmd_ready", up_if.cmd_ready, 1'b0);
    checkOutput("por_cmd_valid", dn_if.cmd_valid, 1'b0);
    checkOutput("por_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_ready", up_if.cmd_ready, 1'b1);

    // Table-driven fill, full-with-pop and ordering
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].cv, mk_cmd(1'b0, vecs[i].addr, ~vecs[i].addr, 4'hF),
                    vecs[i].o_rdy, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d_cmd_ready", i), up_if.cmd_ready, vecs[i].exp_ready);
      checkOutput($sformatf("vec%0d_cmd_valid", i), dn_if.cmd_valid, vecs[i].exp_ovalid);
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      if (vecs[i].exp_ovalid)
        checkValue($sformatf("vec%0d_cmd_addr", i), 96'(dn_if.cmd_addr), 96'(vecs[i].exp_addr));
    end

    // Single write: one cycle command latency, response error clear
    doReset();
    applyStimulus(1'b1, mk_cmd(1'b0, 32'h1000_4000, 32'h5, 4'hF), 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wr_accept", up_if.cmd_ready, 1'b1);
    checkOutput("wr_no_bypass", dn_if.cmd_valid, 1'b0);
    applyStimulus(1'b0, idle_cmd, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wr_cmd_valid", dn_if.cmd_valid, 1'b1);
    checkValue("wr_cmd_addr", 96'(dn_if.cmd_addr), 96'(32'h1000_4000));
    checkValue("wr_cmd_wdata", 96'(dn_if.cmd_wdata), 96'(32'h5));
    checkValue("wr_cmd_wmask", 96'(dn_if.cmd_wmask), 96'(4'hF));
    checkOutput("wr_cmd_read", dn_if.cmd_read, 1'b0);
    applyStimulus(1'b0, idle_cmd, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
    checkOutput("wr_cmd_popped", dn_if.cmd_valid, 1'b0);
`ifdef ICB_PIPE_BRIDGE_RSP_BUF_EN
    checkOutput("wr_rsp_latency", up_if.rsp_valid, 1'b0);
    applyStimulus(1'b0, idle_cmd, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
`endif
    checkOutput("wr_rsp_valid", up_if.rsp_valid, 1'b1);
    checkOutput("wr_rsp_err", up_if.rsp_err, 1'b0);
    applyStimulus(1'b0, idle_cmd, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wr_busy_clear", busy, 1'b0);

    // Read returning rdata=7, err=1 reaches upstream unchanged
    applyStimulus(1'b1, mk_cmd(1'b1, 32'h1000_4008, 32'h0, 4'h0), 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, idle_cmd, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("rd_cmd_read", dn_if.cmd_read, 1'b1);
    applyStimulus(1'b0, idle_cmd, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b1);
`ifdef ICB_PIPE_BRIDGE_RSP_BUF_EN
    applyStimulus(1'b0, idle_cmd, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
`endif
    checkOutput("rd_rsp_valid", up_if.rsp_valid, 1'b1);
    checkValue("rd_rsp_rdata", 96'(up_if.rsp_rdata), 96'(32'h0000_0007));
    checkOutput("rd_rsp_err", up_if.rsp_err, 1'b1);

    // Outstanding limit: exactly OUTS_MAX accepted while responses stall
    doReset();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, mk_cmd(1'b0, 32'hC00 + 32'(i), 32'(i), 4'hF), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      if (up_if.cmd_ready) acc++;
    end
    checkValue("outs_accept_cnt", 96'(acc), 96'(OUTS_MAX));
    checkOutput("outs_busy", busy, 1'b1);
    checkOutput("outs_blocked", up_if.cmd_ready, 1'b0);

    // One response releases exactly one more command; at the limit the
    // response cycle itself must not accept
    acc = 0;
    rhs = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, mk_cmd(1'b0, 32'hC10 + 32'(i), 32'(i), 4'hF), 1'b1,
                    (i == 0), 32'h55, 1'b0, 1'b1);
      if (up_if.rsp_valid) begin
        rhs++;
        checkOutput("outs_simul_at_max", up_if.cmd_ready, 1'b0);
      end
      if (up_if.cmd_ready) acc++;
    end
    checkValue("outs_release_rsp", 96'(rhs), 96'(1));
    checkValue("outs_release_acc", 96'(acc), 96'(1));
    checkOutput("outs_relimit", up_if.cmd_ready, 1'b0);

    // Drain two responses to bring the count to 2
    rhs = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, idle_cmd, 1'b1, (i < 2), 32'h66, 1'b0, 1'b1);
      if (up_if.rsp_valid) rhs++;
    end
    checkValue("outs_drain_two", 96'(rhs), 96'(2));

    // Accept and response in the same cycle at count 2 keeps the count
`ifdef ICB_PIPE_BRIDGE_RSP_BUF_EN
    applyStimulus(1'b0, idle_cmd, 1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
    orv_b = 1'b0;
`else
    orv_b = 1'b1;
`endif
    applyStimulus(1'b1, mk_cmd(1'b0, 32'hD00, 32'h1, 4'hF), 1'b1, orv_b, 32'h77, 1'b0, 1'b1);
    checkOutput("simul2_cmd_ready", up_if.cmd_ready, 1'b1);
    checkOutput("simul2_rsp_valid", up_if.rsp_valid, 1'b1);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, mk_cmd(1'b0, 32'hD10 + 32'(i), 32'(i), 4'hF), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      if (up_if.cmd_ready) acc++;
    end
    checkValue("simul2_count_kept", 96'(acc), 96'(2));

    // Reset with two queued commands clears outputs at once, nothing stale
    doReset();
    applyStimulus(1'b1, mk_cmd(1'b0, 32'hB0, 32'h1, 4'hF), 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, mk_cmd(1'b0, 32'hB4, 32'h2, 4'hF), 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, idle_cmd, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("mid_queued_valid", dn_if.cmd_valid, 1'b1);
    checkOutput("mid_queued_full", up_if.cmd_ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_cmd_valid", dn_if.cmd_valid, 1'b0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_rsp_valid", up_if.rsp_valid, 1'b0);
    checkOutput("mid_rst_cmd_ready", up_if.cmd_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, idle_cmd, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("post_rst_cmd_valid", dn_if.cmd_valid, 1'b0);
      checkOutput("post_rst_rsp_valid", up_if.rsp_valid, 1'b0);
      checkOutput("post_rst_busy", busy, 1'b0);
      checkOutput("post_rst_cmd_ready", up_if.cmd_ready, 1'b1);
    end

    // Randomized traffic against the model
    doReset();
    mq.delete();
    exp_q.delete();
    pend_q.delete();
    outs = 0;
    for (int n = 0; n < 1500; n++) randomCycle(1'b1);
    guard = 0;
    while (((outs != 0) || (mq.size() != 0)) && (guard < 300)) begin
      randomCycle(1'b0);
      guard++;
    end
    checkOutput("drain_in_time", guard < 300, 1'b1);
    applyStimulus(1'b0, idle_cmd, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("drain_busy", busy, 1'b0);
    checkValue("drain_scoreboard", 96'(exp_q.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
